// File: rtl/preg_free_list.sv
// Physical-register free list: ring of free preg tags with per-branch head checkpoints.
// Optional FREE_LIST_DUP_CHECK_EN adds an is_free bitmap, double-free detection and rebuild after recovery.
module preg_free_list #(
  parameter int NUM_PREGS = 128,
  parameter int NUM_AREGS = 32,
  parameter int ROB_DEPTH = 32,
  localparam int PW = $clog2(NUM_PREGS),
  localparam int TW = $clog2(ROB_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc_req,
  output logic          alloc_valid,
  output logic [PW-1:0] alloc_preg,
  input  logic          retire_valid,
  input  logic [PW-1:0] retire_preg,
  input  logic          ckpt_valid,
  input  logic [TW-1:0] ckpt_tag,
  input  logic          mispredict,
  input  logic [TW-1:0] mispredict_tag,
`ifdef FREE_LIST_DUP_CHECK_EN
  output logic          dbl_free_err,
`endif
  output logic [PW-1:0] free_count
);

  localparam int INIT_FREE = NUM_PREGS - NUM_AREGS;

  logic [PW-1:0] ring_q [NUM_PREGS];
  logic [PW-1:0] ring_d [NUM_PREGS];
  logic [PW-1:0] ckpt_q [ROB_DEPTH];
  logic [PW-1:0] ckpt_d [ROB_DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] free_count_q, free_count_d;
  logic          pop, push, push_raw, alloc_ok;

  assign push_raw    = retire_valid && (retire_preg != '0);
  assign alloc_valid = alloc_ok && (free_count_q != '0) && !mispredict && !reset;
  assign alloc_preg  = ring_q[head_q];
  assign free_count  = free_count_q;
  assign pop         = alloc_req && alloc_valid;

`ifdef FREE_LIST_DUP_CHECK_EN
  logic [NUM_PREGS-1:0] is_free_q, is_free_d;
  logic                 rb_active_q, rb_active_d;
  logic [PW-1:0]        rb_ptr_q, rb_ptr_d;
  logic [PW-1:0]        rb_end_q, rb_end_d;
  logic                 dbl_free_err_q, dbl_free_err_d;

  assign alloc_ok     = !rb_active_q;
  assign push         = push_raw && !is_free_q[retire_preg];
  assign dbl_free_err = dbl_free_err_q;

  always_comb begin
    is_free_d      = is_free_q;
    rb_active_d    = rb_active_q;
    rb_ptr_d       = rb_ptr_q;
    rb_end_d       = rb_end_q;
    dbl_free_err_d = push_raw && is_free_q[retire_preg];
    // Walk the reclaimed window one entry per cycle, re-marking each as free.
    if (rb_active_q)
      is_free_d[ring_q[rb_ptr_q]] = 1'b1;
    if (mispredict) begin
      rb_ptr_d    = ckpt_q[mispredict_tag];
      rb_end_d    = rb_active_q ? rb_end_q : head_q;
      rb_active_d = (rb_ptr_d != rb_end_d);
    end else if (rb_active_q) begin
      rb_ptr_d    = rb_ptr_q + 1'b1;
      rb_active_d = (rb_ptr_d != rb_end_q);
    end
    if (pop)  is_free_d[alloc_preg]  = 1'b0;
    if (push) is_free_d[retire_preg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++)
        is_free_q[i] <= (i >= NUM_AREGS);
      rb_active_q    <= 1'b0;
      rb_ptr_q       <= '0;
      rb_end_q       <= '0;
      dbl_free_err_q <= 1'b0;
    end else begin
      is_free_q      <= is_free_d;
      rb_active_q    <= rb_active_d;
      rb_ptr_q       <= rb_ptr_d;
      rb_end_q       <= rb_end_d;
      dbl_free_err_q <= dbl_free_err_d;
    end
  end
`else
  assign alloc_ok = 1'b1;
  assign push     = push_raw;
`endif

  always_comb begin
    ring_d = ring_q;
    ckpt_d = ckpt_q;
    if (push) ring_d[tail_q] = retire_preg;
    tail_d = tail_q + PW'(push);
    head_d = mispredict ? ckpt_q[mispredict_tag] : head_q + PW'(pop);
    // head_d already includes this cycle's pop, so the branch keeps its own rd.
    if (ckpt_valid && !mispredict) ckpt_d[ckpt_tag] = head_d;
    free_count_d = tail_d - head_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++)
        ring_q[i] <= (i < INIT_FREE) ? PW'(NUM_AREGS + i) : '0;
      for (int i = 0; i < ROB_DEPTH; i++)
        ckpt_q[i] <= '0;
      head_q       <= '0;
      tail_q       <= PW'(INIT_FREE);
      free_count_q <= PW'(INIT_FREE);
    end else begin
      ring_q       <= ring_d;
      ckpt_q       <= ckpt_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      free_count_q <= free_count_d;
    end
  end

endmodule

// File: tb/tb_preg_free_list.sv
// Randomized bench for preg_free_list against a history-array model of the free list.
module tb_preg_free_list;
  localparam int PW = 7;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          alloc_req, alloc_valid;
  logic [PW-1:0] alloc_preg;
  logic          retire_valid;
  logic [PW-1:0] retire_preg;
  logic          ckpt_valid;
  logic [TW-1:0] ckpt_tag;
  logic          mispredict;
  logic [TW-1:0] mispredict_tag;
  logic [PW-1:0] free_count;
`ifdef FREE_LIST_DUP_CHECK_EN
  logic          dbl_free_err;
`endif

  preg_free_list dut (
    .clk(clk), .reset(reset),
    .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_preg(alloc_preg),
    .retire_valid(retire_valid), .retire_preg(retire_preg),
    .ckpt_valid(ckpt_valid), .ckpt_tag(ckpt_tag),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag),
`ifdef FREE_LIST_DUP_CHECK_EN
    .dbl_free_err(dbl_free_err),
`endif
    .free_count(free_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: every tag ever pushed, in order; free list is hist[pop_n .. push_n-1].
  int hist[$];
  int pop_n, push_n;
  int ck_val [32];
  bit ck_ok  [32];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 96; i++) hist.push_back(32 + i);
    pop_n  = 0;
    push_n = 96;
    for (int i = 0; i < 32; i++) begin ck_val[i] = 0; ck_ok[i] = 1'b0; end
  endtask

  // Entered and left at a negedge; drives one cycle of inputs.
  task automatic do_reset();
    reset = 1'b1; alloc_req = 0; retire_valid = 0; retire_preg = '0;
    ckpt_valid = 0; ckpt_tag = '0; mispredict = 0; mispredict_tag = '0;
    #1 chk("alloc_valid_in_reset", alloc_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic step(input bit req, input bit rv, input int rp,
                      input bit cv, input int ct, input bit mp, input int mt);
    int  exp_fc, new_pop;
    bit  exp_av, do_pop;
    alloc_req = req; retire_valid = rv; retire_preg = PW'(rp);
    ckpt_valid = cv; ckpt_tag = TW'(ct); mispredict = mp; mispredict_tag = TW'(mt);
    #1;
    exp_fc = push_n - pop_n;
    exp_av = (exp_fc != 0) && !mp;
    chk("free_count", free_count, exp_fc);
    chk("alloc_valid", alloc_valid, exp_av);
    if (exp_av) chk("alloc_preg", alloc_preg, hist[pop_n]);
    do_pop  = req && exp_av;
    new_pop = mp ? ck_val[mt] : pop_n + do_pop;
    if (cv && !mp) begin ck_val[ct] = new_pop; ck_ok[ct] = 1'b1; end
    if (mp)
      for (int i = 0; i < 32; i++) if (ck_val[i] > new_pop) ck_ok[i] = 1'b0;
    if (rv && rp != 0) begin hist.push_back(rp); push_n++; end
    pop_n = new_pop;
    @(negedge clk);
  endtask

  task automatic pops(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int fc0;
    @(negedge clk);

    // First allocations after reset
    do_reset();
    pops(3);
    chk("fc_after_3_pops", free_count, 93);

    // Drain, then push into empty list: offered only next cycle
    do_reset();
    pops(96);
    chk("drained_valid", alloc_valid, 0);
    chk("drained_fc", free_count, 0);
    step(1, 1, 40, 0, 0, 0, 0);
    chk("refill_valid", alloc_valid, 1);
    chk("refill_preg", alloc_preg, 40);

    // Checkpoint after 2 pops, 4 more pops, then recover
    do_reset();
    pops(2);
    step(0, 0, 0, 1, 5, 0, 0);
    pops(4);
    step(1, 0, 0, 0, 0, 1, 5);
    chk("recover_preg", alloc_preg, 34);
    chk("recover_fc", free_count, 94);

    // Same-cycle pop and push of 7; 7 lands at ring[96]
    do_reset();
    step(1, 1, 7, 0, 0, 0, 0);
    chk("pop_push_fc", free_count, 96);
    pops(95);
    chk("pushed_7_head", alloc_preg, 7);

    // p0 is never pushed
    do_reset();
    pops(5);
    fc0 = free_count;
    step(0, 1, 0, 0, 0, 0, 0);
    chk("p0_push_fc", free_count, fc0);

    // Reset mid-stream
    do_reset();
    pops(10);
    do_reset();
    chk("mid_reset_fc", free_count, 96);
    chk("mid_reset_preg", alloc_preg, 32);

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit req, rv, cv, mp;
      int rp, ct, mt;
      req = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 9) < 5) && (push_n - pop_n < 96);
      rp  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 127);
      cv  = ($urandom_range(0, 9) == 0);
      ct  = $urandom_range(0, 31);
      mt  = $urandom_range(0, 31);
      mp  = ($urandom_range(0, 29) == 0) && ck_ok[mt] && (ck_val[mt] <= pop_n) &&
            (push_n + (rv && rp != 0) - ck_val[mt] <= 96);
      step(req, rv, rp, cv, ct, mp, mt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
